intr_ctrl: RTL and testbench

Programmable interrupt controller between the timer/external interrupt sources and the CPU's exception logic. It synchronises up to six raw request lines and latches edge-triggered ones. It applies a software mask and picks the highest-priority pending source, then holds a request/acknowledge/end-of-interrupt handshake with the CPU. Software reaches its four registers through the bridge as one more device slot (word address, write enable, 32-bit data).

---
 rtl/intr_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_intr_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// intr_ctrl: synchronised, maskable, fixed-priority interrupt controller with a
// req/ack/EOI CPU handshake. Define INTR_CTRL_NEST_EN to allow nested service.
module intr_ctrl #(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [29:0]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [N_SRC-1:0] src_irq,
  output logic             int_req,
  output logic [2:0]       int_id,
  input  logic             int_ack
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_INSERV = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [N_SRC-1:0] sync1_reg, sync2_reg, sync_d_reg;
  logic [N_SRC-1:0] mask_reg, edge_reg, pend_reg, pend_next;
  logic [N_SRC-1:0] inserv_reg, inserv_next;
  logic [2:0]       id_reg, id_next;

  logic [N_SRC-1:0] eff;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pend_clr;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] id_onehot;
  logic             eff_any;
  logic [2:0]       win_id;
  logic             isv_any;
  logic [2:0]       isv_id;

  logic wr_mask, wr_edge, wr_pend, wr_eoi;

  logic unused_ok;
  assign unused_ok = ^{Addr[29:2], Din[31:N_SRC]};

  assign wr_mask = WE && (Addr[1:0] == 2'd0);
  assign wr_edge = WE && (Addr[1:0] == 2'd1);
  assign wr_pend = WE && (Addr[1:0] == 2'd2);
  assign wr_eoi  = WE && (Addr[1:0] == 2'd3);

  assign eff     = pend_reg & mask_reg;
  assign eff_any = |eff;
  assign isv_any = |inserv_reg;

  assign pend_clr = (wr_pend ? Din[N_SRC-1:0] : '0) | ack_clr;

  // Per-source pending update; a fresh rising edge beats any clear in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_pend
      assign rise[gi]      = sync2_reg[gi] & ~sync_d_reg[gi];
      assign pend_next[gi] = edge_reg[gi]
                           ? ((pend_reg[gi] & ~pend_clr[gi]) | rise[gi])
                           : sync2_reg[gi];
    end
  endgenerate

  always_comb begin
    win_id = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eff[i]) win_id = i[2:0];
    end
  end

  always_comb begin
    isv_id = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (inserv_reg[i]) isv_id = i[2:0];
    end
  end

  always_comb begin
    id_onehot         = '0;
    id_onehot[id_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      sync_d_reg <= '0;
      mask_reg   <= '0;
      edge_reg   <= '0;
      pend_reg   <= '0;
      inserv_reg <= '0;
    end else begin
      sync1_reg  <= src_irq;
      sync2_reg  <= sync1_reg;
      sync_d_reg <= sync2_reg;
      if (wr_mask) mask_reg <= Din[N_SRC-1:0];
      if (wr_edge) edge_reg <= Din[N_SRC-1:0];
      pend_reg   <= pend_next;
      inserv_reg <= inserv_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      id_reg    <= 3'd0;
    end else begin
      state_reg <= state_next;
      id_reg    <= id_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    id_next     = id_reg;
    inserv_next = inserv_reg;
    ack_clr     = '0;
`ifdef INTR_CTRL_NEST_EN
    // EOI retires the highest-priority (lowest-index) service level.
    if (wr_eoi && isv_any) inserv_next[isv_id] = 1'b0;
`endif
    case (state_reg)
      S_IDLE: begin
        if (eff_any) begin
          state_next = S_REQ;
          id_next    = win_id;
        end
      end
      S_REQ: begin
        // Ack takes priority over a request withdrawn in the same cycle.
        if (int_ack) begin
          state_next          = S_INSERV;
          inserv_next[id_reg] = 1'b1;
          ack_clr             = id_onehot;
        end else if (!eff[id_reg]) begin
          state_next = (|inserv_next) ? S_INSERV : S_IDLE;
        end
      end
      S_INSERV: begin
`ifdef INTR_CTRL_NEST_EN
        if (inserv_next == '0) begin
          state_next = S_IDLE;
        end else if (!wr_eoi && eff_any && (win_id < isv_id)) begin
          state_next = S_REQ;
          id_next    = win_id;
        end
`else
        if (wr_eoi) begin
          inserv_next = '0;
          state_next  = S_IDLE;
        end
`endif
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign int_req = (state_reg == S_REQ);
  assign int_id  = id_reg;

  always_comb begin
    Dout = '0;
    case (Addr[1:0])
      2'd0: Dout[N_SRC-1:0] = mask_reg;
      2'd1: Dout[N_SRC-1:0] = edge_reg;
      2'd2: Dout[N_SRC-1:0] = pend_reg;
      default: begin
        Dout[2:0]           = isv_id;
        Dout[3]             = isv_any;
        Dout[N_SRC+7:8]     = sync2_reg;
        Dout[N_SRC+15:16]   = inserv_reg;
      end
    endcase
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl with a cycle-level reference model and literal checkpoints.
// Honours INTR_CTRL_NEST_EN the same way as the design.
module tb_intr_ctrl;
  localparam int N = 6;

  logic         clk;
  logic         reset;
  logic [29:0]  Addr;
  logic         WE;
  logic [31:0]  Din;
  logic [31:0]  Dout;
  logic [N-1:0] src_irq;
  logic         int_req;
  logic [2:0]   int_id;
  logic         int_ack;

  int total = 0;
  int bad   = 0;

  intr_ctrl #(.N_SRC(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .src_irq (src_irq),
    .int_req (int_req),
    .int_id  (int_id),
    .int_ack (int_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0] m_s1, m_s2, m_s3, m_mask, m_edge, m_pend, m_isv;
  logic         m_req;
  int           m_id;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin : model
    logic [N-1:0] eff, w1c, clr, n_isv, n_pend;
    logic         n_req, eoi;
    int           n_id;
    if (!reset) begin
      m_s1 <= '0; m_s2 <= '0; m_s3 <= '0;
      m_mask <= '0; m_edge <= '0; m_pend <= '0; m_isv <= '0;
      m_req <= 1'b0; m_id <= 0;
    end else begin
      eff   = m_pend & m_mask;
      eoi   = WE && (Addr[1:0] == 2'd3);
      w1c   = (WE && (Addr[1:0] == 2'd2)) ? Din[N-1:0] : '0;
      n_isv = m_isv;
      n_req = m_req;
      n_id  = m_id;
      clr   = '0;
`ifdef INTR_CTRL_NEST_EN
      if (eoi && m_isv != '0) n_isv[lowest(m_isv)] = 1'b0;
`endif
      if (m_req) begin
        if (int_ack) begin
          n_req = 1'b0; n_isv[m_id] = 1'b1; clr[m_id] = 1'b1;
        end else if (!eff[m_id]) begin
          n_req = 1'b0;
        end
      end else if (m_isv == '0) begin
        if (eff != '0) begin n_req = 1'b1; n_id = lowest(eff); end
      end else begin
`ifdef INTR_CTRL_NEST_EN
        if (n_isv != '0 && !eoi && eff != '0 && lowest(eff) < lowest(m_isv)) begin
          n_req = 1'b1; n_id = lowest(eff);
        end
`else
        if (eoi) n_isv = '0;
`endif
      end
      for (int i = 0; i < N; i++)
        n_pend[i] = m_edge[i] ? ((m_s2[i] & ~m_s3[i]) | (m_pend[i] & ~w1c[i] & ~clr[i]))
                              : m_s2[i];
      m_s1 <= src_irq; m_s2 <= m_s1; m_s3 <= m_s2;
      if (WE && Addr[1:0] == 2'd0) m_mask <= Din[N-1:0];
      if (WE && Addr[1:0] == 2'd1) m_edge <= Din[N-1:0];
      m_pend <= n_pend; m_isv <= n_isv; m_req <= n_req; m_id <= n_id;
    end
  end

  function automatic logic [31:0] model_dout(input logic [1:0] a);
    logic [31:0] d;
    d = '0;
    case (a)
      2'd0: d[N-1:0] = m_mask;
      2'd1: d[N-1:0] = m_edge;
      2'd2: d[N-1:0] = m_pend;
      default: begin
        d[2:0]      = 3'(lowest(m_isv));
        d[3]        = (m_isv != '0);
        d[N+7:8]    = m_s2;
        d[N+15:16]  = m_isv;
      end
    endcase
    return d;
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("cyc_int_req", {31'd0, int_req}, {31'd0, m_req});
    check("cyc_int_id", {29'd0, int_id}, 32'(m_id));
    check("cyc_dout", Dout, model_dout(Addr[1:0]));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = {28'd0, a}; Din = d; WE = 1'b1;
    tick();
    WE = 1'b0;
    $display("write addr=%0d data=0x%08h", a, d);
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    $display("ack id=%0d", int_id);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    Addr = {28'd0, a};
    #1;
    check(name, Dout, exp);
    $display("read addr=%0d data=0x%08h", a, Dout);
  endtask

  task automatic req_chk(input string name, input logic r, input logic [2:0] id);
    check({name, "_req"}, {31'd0, int_req}, {31'd0, r});
    if (r) check({name, "_id"}, {29'd0, int_id}, {29'd0, id});
  endtask

  initial begin
    reset = 1'b0; Addr = '0; WE = 1'b0; Din = '0; src_irq = '0; int_ack = 1'b0;
    ticks(3);
    rd_chk("rst_mask", 2'd0, 32'h0);
    rd_chk("rst_edge", 2'd1, 32'h0);
    rd_chk("rst_pend", 2'd2, 32'h0);
    rd_chk("rst_stat", 2'd3, 32'h0);
    req_chk("rst", 1'b0, 3'd0);
    reset = 1'b1;
    tick();

    // Level source 2: three-cycle latency, ack, EOI re-request.
    wr(2'd0, 32'h3F);
    src_irq[2] = 1'b1;
    ticks(3);
    req_chk("lvl_pre", 1'b0, 3'd0);
    tick();
    req_chk("lvl_lat3", 1'b1, 3'd2);
    rd_chk("lvl_pend", 2'd2, 32'h04);
    ack();
    req_chk("lvl_after_ack", 1'b0, 3'd0);
    rd_chk("lvl_stat", 2'd3, 32'h0004040A);
    wr(2'd3, 32'h0);
    req_chk("eoi_idle", 1'b0, 3'd0);
    tick();
    req_chk("eoi_rereq", 1'b1, 3'd2);
    ack();
    src_irq[2] = 1'b0;
    ticks(3);
    wr(2'd3, 32'h0);
    ticks(2);
    req_chk("lvl_quiet", 1'b0, 3'd0);

    // Edge source 0: latch, ack clear, set beats W1C.
    wr(2'd1, 32'h01);
    src_irq[0] = 1'b1; tick(); src_irq[0] = 1'b0;
    ticks(2);
    rd_chk("edge_pend_set", 2'd2, 32'h01);
    ticks(3);
    rd_chk("edge_pend_hold", 2'd2, 32'h01);
    req_chk("edge_req", 1'b1, 3'd0);
    ack();
    rd_chk("edge_ack_clr", 2'd2, 32'h00);
    rd_chk("edge_stat", 2'd3, 32'h00010008);
    wr(2'd3, 32'h0);
    tick();
    req_chk("edge_idle", 1'b0, 3'd0);
    src_irq[0] = 1'b1; tick(); src_irq[0] = 1'b0;
    ticks(3);
    src_irq[0] = 1'b1; tick(); src_irq[0] = 1'b0;
    tick();
    wr(2'd2, 32'h01);
    rd_chk("w1c_vs_set", 2'd2, 32'h01);
    wr(2'd2, 32'h01);
    rd_chk("w1c_clear", 2'd2, 32'h00);
    tick();
    req_chk("w1c_withdraw", 1'b0, 3'd0);
    wr(2'd1, 32'h0);

    // Sources 4 and 1 together: lowest index first.
    wr(2'd1, 32'h12);
    src_irq = 6'b010010;
    ticks(4);
    req_chk("prio_first", 1'b1, 3'd1);
    ack();
    wr(2'd3, 32'h0);
    tick();
    req_chk("prio_second", 1'b1, 3'd4);
    ack();
    wr(2'd3, 32'h0);
    src_irq = '0;
    ticks(3);
    wr(2'd1, 32'h0);
    ticks(2);

    // Level source 3 withdrawn before ack; late ack ignored.
    src_irq = 6'b001000;
    ticks(4);
    req_chk("wd_req", 1'b1, 3'd3);
    src_irq = '0;
    ticks(3);
    req_chk("wd_still", 1'b1, 3'd3);
    tick();
    req_chk("wd_drop", 1'b0, 3'd0);
    ack();
    req_chk("wd_ack_ign", 1'b0, 3'd0);
    rd_chk("wd_stat", 2'd3, 32'h0);

    // Reset while requesting.
    wr(2'd1, 32'h05);
    src_irq = 6'b001000;
    ticks(4);
    req_chk("rst_mid_pre", 1'b1, 3'd3);
    reset = 1'b0;
    #1;
    check("rst_mid_req", {31'd0, int_req}, 32'h0);
    check("rst_mid_id", {29'd0, int_id}, 32'h0);
    rd_chk("rst_mid_mask", 2'd0, 32'h0);
    rd_chk("rst_mid_edge", 2'd1, 32'h0);
    rd_chk("rst_mid_pend", 2'd2, 32'h0);
    src_irq = '0;
    ticks(2);
    reset = 1'b1;
    tick();

    // Source 5 in service, source 0 arrives.
    wr(2'd0, 32'h3F);
    src_irq = 6'b100000;
    ticks(4);
    req_chk("nest_first", 1'b1, 3'd5);
    ack();
    src_irq = 6'b100001;
    ticks(4);
`ifdef INTR_CTRL_NEST_EN
    req_chk("nest_preempt", 1'b1, 3'd0);
    ack();
    rd_chk("nest_stat2", 2'd3, 32'h00212108);
    wr(2'd3, 32'h0);
    rd_chk("nest_eoi1", 2'd3, 32'h0020210D);
`else
    req_chk("single_lock", 1'b0, 3'd0);
    rd_chk("single_stat", 2'd3, 32'h0020210D);
    wr(2'd3, 32'h0);
    tick();
    req_chk("single_next", 1'b1, 3'd0);
`endif
    src_irq = '0;
    ticks(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
